// File: rtl/dvsd_8216m9_acc.sv
// Windowed accumulator for 16-bit multiplier products: sums LEN products (0 = 256) and
// presents the total with a valid/ready handshake. Define DVSD_ACC_SATURATE_EN to clamp on overflow.
module dvsd_8216m9_acc #(
    parameter int ACC_W = 24
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [15:0]      M,
    input  logic             M_VALID,
    output logic             M_READY,
    input  logic [7:0]       LEN,
    output logic [ACC_W-1:0] S,
    output logic             S_VALID,
    input  logic             S_READY,
    output logic             OVF,
    output logic [7:0]       CNT
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       len_q, len_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             consume;
    logic [ACC_W-1:0] m_ext;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic [ACC_W-1:0] acc_upd;
    logic [7:0]       cnt_inc;

    assign M_READY = (state_q != DONE);
    assign S_VALID = (state_q == DONE);
    assign S       = acc_q;
    assign OVF     = ovf_q;
    assign CNT     = cnt_q;

    assign accept  = M_VALID && M_READY;
    assign consume = S_VALID && S_READY;
    assign m_ext   = ACC_W'(M);
    assign sum     = {1'b0, acc_q} + {1'b0, m_ext};
    assign carry   = sum[ACC_W];
    // 8-bit count wraps 255 -> 0, which is exactly how LEN=0 encodes a 256-product window.
    assign cnt_inc = cnt_q + 8'd1;

`ifdef DVSD_ACC_SATURATE_EN
    // Once clamped the accumulator stays at full scale until the window is consumed.
    assign acc_upd = (carry || ovf_q) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_upd = sum[ACC_W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    len_d   = LEN;
                    acc_d   = m_ext;
                    cnt_d   = 8'd1;
                    ovf_d   = 1'b0;
                    state_d = (LEN == 8'd1) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = acc_upd;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | carry;
                    if (cnt_inc == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (consume) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = 8'd0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = 8'd0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= 8'd0;
            len_q   <= 8'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_dvsd_8216m9_acc.sv
// Directed bench for dvsd_8216m9_acc: a 24-bit and a 16-bit instance share all stimulus;
// expected window sums are queued when a window is driven and checked when S_VALID appears.
module tb_dvsd_8216m9_acc;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] M;
    logic        M_VALID;
    logic [7:0]  LEN;
    logic        S_READY;

    logic        M_READY,  S_VALID,  OVF;
    logic [23:0] S;
    logic [7:0]  CNT;
    logic        M_READY16, S_VALID16, OVF16;
    logic [15:0] S16;
    logic [7:0]  CNT16;

    typedef struct {
        logic [23:0] s24;
        logic        ovf24;
        logic [15:0] s16;
        logic        ovf16;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] data_q[$];
    int          total = 0;
    int          bad   = 0;

    always #5 CLK = ~CLK;

    dvsd_8216m9_acc #(.ACC_W(24)) dut (
        .CLK(CLK), .RST(RST), .M(M), .M_VALID(M_VALID), .M_READY(M_READY),
        .LEN(LEN), .S(S), .S_VALID(S_VALID), .S_READY(S_READY), .OVF(OVF), .CNT(CNT)
    );

    dvsd_8216m9_acc #(.ACC_W(16)) dut16 (
        .CLK(CLK), .RST(RST), .M(M), .M_VALID(M_VALID), .M_READY(M_READY16),
        .LEN(LEN), .S(S16), .S_VALID(S_VALID16), .S_READY(S_READY), .OVF(OVF16), .CNT(CNT16)
    );

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives data_q as one window; LEN is scrambled after the first accept to prove it is latched.
    task automatic run_window(input logic [7:0] len);
        logic [63:0] full;
        exp_t        e;
        full = 64'd0;
        foreach (data_q[i]) full += 64'(data_q[i]);
        e.ovf24 = (full > 64'hFF_FFFF);
        e.s24   = full[23:0];
        e.ovf16 = (full > 64'hFFFF);
`ifdef DVSD_ACC_SATURATE_EN
        e.s16   = e.ovf16 ? 16'hFFFF : full[15:0];
`else
        e.s16   = full[15:0];
`endif
        sb.push_back(e);
        LEN = len;
        foreach (data_q[i]) begin
            chk("m_ready_in_window", M_READY, 1'b1);
            chk("s_valid_early", S_VALID, 1'b0);
            M       = data_q[i];
            M_VALID = 1'b1;
            cyc();
            LEN = len ^ 8'hA5;
            chk("cnt_running", CNT, 32'((i + 1) & 8'hFF));
        end
        M_VALID = 1'b0;
        data_q.delete();
    endtask

    // Waits for the sum, compares it with the queue head, optionally stalls with M_VALID high, then consumes it.
    task automatic collect(input int stall);
        exp_t        e;
        logic [23:0] s_hold;
        logic [7:0]  cnt_hold;
        int          n = 0;
        while (!S_VALID && n < 20) begin
            cyc();
            n++;
        end
        chk("s_valid_wait", S_VALID, 1'b1);
        chk("m_ready_in_done", M_READY, 1'b0);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'(sb.size()), 1);
        end else begin
            e = sb.pop_front();
            chk("s24", S, e.s24);
            chk("ovf24", OVF, e.ovf24);
            chk("s16", S16, e.s16);
            chk("ovf16", OVF16, e.ovf16);
            chk("s_valid16", S_VALID16, 1'b1);
        end
        s_hold   = S;
        cnt_hold = CNT;
        S_READY  = 1'b0;
        for (int k = 0; k < stall; k++) begin
            M       = 16'h0055;
            M_VALID = 1'b1;
            cyc();
            chk("stall_s", S, s_hold);
            chk("stall_cnt", CNT, cnt_hold);
            chk("stall_ovf", OVF, e.ovf24);
            chk("stall_s_valid", S_VALID, 1'b1);
            chk("stall_m_ready", M_READY, 1'b0);
        end
        S_READY = 1'b1;
        cyc();
        S_READY = 1'b0;
        M_VALID = 1'b0;
        chk("idle_s_valid", S_VALID, 1'b0);
        chk("idle_m_ready", M_READY, 1'b1);
        chk("idle_cnt", CNT, 8'd0);
        chk("idle_s", S, 24'd0);
        chk("idle_ovf", OVF, 1'b0);
    endtask

    initial begin
        RST     = 1'b1;
        M       = 16'h0;
        M_VALID = 1'b0;
        LEN     = 8'd0;
        S_READY = 1'b0;
        cyc();
        cyc();
        RST = 1'b0;
        chk("rst_s_valid", S_VALID, 1'b0);
        chk("rst_m_ready", M_READY, 1'b1);
        chk("rst_cnt", CNT, 8'd0);
        chk("rst_s", S, 24'd0);
        chk("rst_ovf", OVF, 1'b0);

        // LEN=3: 1+2+3
        data_q = '{16'h0001, 16'h0002, 16'h0003};
        run_window(8'd3);
        chk("len3_s_valid", S_VALID, 1'b1);
        chk("len3_s", S, 24'd6);
        chk("len3_cnt", CNT, 8'd3);
        chk("len3_ovf", OVF, 1'b0);
        collect(0);
        $display("txn len=3 products=1,2,3 S=%0d", 6);

        // LEN=1: single 255*255 product
        data_q = '{16'hFE01};
        run_window(8'd1);
        chk("len1_s", S, 24'h00FE01);
        chk("len1_m_ready", M_READY, 1'b0);
        collect(0);
        $display("txn len=1 product=0xFE01");

        // Stalled consume with M_VALID held high
        data_q = '{16'd10, 16'd20};
        run_window(8'd2);
        collect(5);
        $display("txn len=2 stalled 5 cycles S=30");

        // Overflow at 16 bits, none at 24 bits
        data_q = '{16'hFFFF, 16'hFFFF};
        run_window(8'd2);
        collect(0);
        $display("txn len=2 products=0xFFFF,0xFFFF overflow check");

        // Reset mid-window with a simultaneous product offered
        LEN = 8'd4;
        M_VALID = 1'b1;
        M = 16'd9;
        cyc();
        cyc();
        chk("partial_cnt", CNT, 8'd2);
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        M_VALID = 1'b0;
        chk("mid_rst_cnt", CNT, 8'd0);
        chk("mid_rst_s_valid", S_VALID, 1'b0);
        chk("mid_rst_m_ready", M_READY, 1'b1);
        chk("mid_rst_s", S, 24'd0);
        data_q = '{16'd5, 16'd7};
        run_window(8'd2);
        chk("after_rst_s", S, 24'd12);
        collect(0);
        $display("txn reset after 2 accepts, then len=2 S=12");

        // LEN=0 encodes a 256-product window
        for (int i = 0; i < 256; i++) data_q.push_back(16'h0001);
        run_window(8'd0);
        chk("len256_s", S, 24'h000100);
        chk("len256_cnt", CNT, 8'd0);
        collect(0);
        $display("txn len=0 (256) products of 1 S=256");

        chk("sb_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dvsd_8216m9_acc.md
DVSD_8216M9_ACC -- requirements
Module: dvsd_8216m9_acc

Interface
REQ-001 SHALL have parameter: ACC_W, 24, accumulator/result width in bits; legal range 16..32.
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: M  input  16  product from upstream 8x8 multiplier, unsigned.
REQ-005 SHALL have port: M_VALID  input  1  M holds a product to accumulate.
REQ-006 SHALL have port: M_READY  output  1  block accepts M this cycle.
REQ-007 SHALL have port: LEN  input  8  window length in products; 0 encodes 256.
REQ-008 SHALL have port: S  output  ACC_W  window sum.
REQ-009 SHALL have port: S_VALID  output  1  S holds a completed window sum.
REQ-010 SHALL have port: S_READY  input  1  downstream consumes S.
REQ-011 SHALL have port: OVF  output  1  sticky per-window overflow flag, valid with S.
REQ-012 SHALL have port: CNT  output  8  products accepted in the current window, low 8 bits.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, ACCUM, DONE.
REQ-014 SHALL accept a product only on M_VALID && M_READY; M_READY SHALL be 1 in IDLE and ACCUM, 0 in DONE.
REQ-015 SHALL, on an accept in IDLE, latch LEN, load ACC=M (zero-extended) and CNT=1, then go to DONE if the latched length is 1, else to ACCUM.
REQ-016 SHALL, on an accept in ACCUM, set ACC=ACC+M and CNT=CNT+1, then go to DONE when the accepted count equals the latched length.
REQ-017 SHALL ignore changes to LEN after it is latched until the window ends.
REQ-018 SHALL assert S_VALID in the cycle after the final product is accepted and hold it high only in DONE.
REQ-019 SHALL keep S and OVF stable while S_VALID=1 && S_READY=0.
REQ-020 SHALL, on S_VALID && S_READY, return to IDLE next cycle and clear ACC, CNT and OVF.
REQ-021 SHALL accept no product in the DONE-to-IDLE handshake cycle, even if M_VALID=1.
REQ-022 SHALL hold state, ACC and CNT unchanged in IDLE and ACCUM when M_VALID=0.
REQ-023 SHALL set OVF when a sum carries out of ACC_W bits; OVF SHALL stay set until the window is consumed or RST is asserted.
REQ-024 SHALL drive S=ACC at all times; S is meaningful only while S_VALID=1.
REQ-025 SHALL never overflow at ACC_W>=24: the maximum sum is 256*65025=16,646,400.

Reset
REQ-026 SHALL, on RST=1 at a clock edge, go to IDLE with ACC=0, CNT=0, OVF=0, S_VALID=0 and M_READY=1 from the next cycle.
REQ-027 SHALL give RST priority over any simultaneous handshake and discard a partial window with no S_VALID pulse.

Configuration
REQ-028 SHALL use the macro DVSD_ACC_SATURATE_EN.
REQ-029 SHALL, when DVSD_ACC_SATURATE_EN is defined, clamp ACC to 2^ACC_W-1 on overflow and keep it there for the rest of the window; OVF is still set.
REQ-030 SHALL, when DVSD_ACC_SATURATE_EN is undefined, wrap ACC modulo 2^ACC_W on overflow and set OVF.

Verification
REQ-031 SHALL test: LEN=3, M=0x0001, 0x0002, 0x0003 on consecutive cycles -> S_VALID high the cycle after the third accept, S=6, OVF=0, CNT=3.
REQ-032 SHALL test: LEN=1, M=0xFE01 (255*255) -> S=0x00FE01 one cycle after the accept; M_READY=0 while S_VALID=1.
REQ-033 SHALL test: window done with S_READY held low 5 cycles and M_VALID=1 -> S, OVF and CNT stable, no product accepted, IDLE after the S_READY pulse.
REQ-034 SHALL test: ACC_W=16, LEN=2, M=0xFFFF twice -> S=0xFFFE, OVF=1 without the macro; S=0xFFFF, OVF=1 with DVSD_ACC_SATURATE_EN.
REQ-035 SHALL test: LEN=4, RST pulsed after 2 accepts -> next cycle CNT=0, S_VALID=0, M_READY=1; then LEN=2, M=5, 7 -> S=12.
REQ-036 SHALL test: LEN=0 with 256 products of 0x0001 -> S_VALID only after the 256th accept, S=0x000100, CNT=0.
